dm_load_unit: RTL and testbench

Data-memory bank and load-return path for the MEM stage. It accepts byte-enabled stores from the store-side byte-enable encoder and commits only the enabled lanes. It serves loads with a fixed one-cycle latency, returning the addressed byte, halfword or word sign- or zero-extended to 32 bits. It flags misaligned accesses for the exception logic.

---
 rtl/dm_pkg.sv | 37 +++
 rtl/dm_load_unit_load_ext.sv | 51 +++++
 rtl/dm_load_unit.sv | 92 +++++++++
 tb/tb_dm_load_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory load/store path: load op codes,
// legal store byte-enable patterns and the store-size codes of the encoder.
package dm_pkg;

    typedef enum logic [2:0] {
        LD_W  = 3'b000,
        LD_HU = 3'b001,
        LD_H  = 3'b010,
        LD_BU = 3'b011,
        LD_B  = 3'b100
    } ld_op_e;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10
    } st_size_e;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_BYTE1   = 4'b0010;
    localparam logic [3:0] BE_BYTE2   = 4'b0100;
    localparam logic [3:0] BE_BYTE3   = 4'b1000;

    // Only naturally aligned word/half/byte patterns may commit; anything else
    // (including 0000) is reported as a store error.
    function automatic logic be_legal(input logic [3:0] be);
        case (be)
            BE_WORD, BE_HALF_LO, BE_HALF_HI,
            BE_BYTE0, BE_BYTE1, BE_BYTE2, BE_BYTE3: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dm_load_unit_load_ext.sv
// Load-return lane select with sign/zero extension and alignment check.
// Purely combinational; operates on the registered word, offset and op.
module load_ext
    import dm_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  op,
    output logic [31:0] rdata,
    output logic        adel
);

    logic [15:0] half;
    logic [7:0]  byte_lane;

    always_comb begin
        half = offset[1] ? word[31:16] : word[15:0];
        case (offset)
            2'd0:    byte_lane = word[7:0];
            2'd1:    byte_lane = word[15:8];
            2'd2:    byte_lane = word[23:16];
            default: byte_lane = word[31:24];
        endcase
    end

    // NOTE: defaults first so every path assigns both outputs; no latches.
    always_comb begin
        rdata = '0;
        adel  = 1'b0;
        case (op)
            LD_H, LD_HU: begin
                if (offset[0])
                    adel = 1'b1;
                else if (op == LD_H)
                    rdata = {{16{half[15]}}, half};
                else
                    rdata = {16'h0000, half};
            end
            LD_B:  rdata = {{24{byte_lane[7]}}, byte_lane};
            LD_BU: rdata = {24'h000000, byte_lane};
            // Reserved encodings 101-111 behave as lw.
            default: begin
                if (offset != 2'b00)
                    adel = 1'b1;
                else
                    rdata = word;
            end
        endcase
    end

endmodule

// File: rtl/dm_load_unit.sv
// MEM-stage data memory: byte-enabled stores, one-cycle loads with
// extension, and misalignment / illegal-enable error pulses.
module dm_load_unit
    import dm_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    input  logic [2:0]  ld_op,
    output logic        rd_valid,
    output logic [31:0] rdata,
    output logic        adel,
    output logic        ades
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] idx;
    logic                  store_ok;
    logic                  store_bad;
    logic                  load_req;

    logic                  rd_valid_q;
    logic                  ades_q;
    logic [31:0]           word_q;
    logic [1:0]            offset_q;
    logic [2:0]            op_q;
    logic [31:0]           ext_rdata;
    logic                  ext_adel;

    // Upper address bits alias onto the array and are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[31:DEPTH_LOG2+2];

    assign idx       = addr[DEPTH_LOG2+1:2];
    assign store_ok  = req_valid & we & be_legal(be);
    assign store_bad = req_valid & we & ~be_legal(be);
    assign load_req  = req_valid & ~we;

    // NOTE: the array is deliberately left out of reset so it maps to RAM and
    // keeps its contents across rst_n.
    always_ff @(posedge clk) begin
        if (store_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i])
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so the load captures
    // the word as it stood before this edge's store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            ades_q     <= 1'b0;
            word_q     <= '0;
            offset_q   <= '0;
            op_q       <= LD_W;
        end else begin
            rd_valid_q <= load_req;
            ades_q     <= store_bad;
            if (load_req) begin
                word_q   <= mem[idx];
                offset_q <= addr[1:0];
                op_q     <= ld_op;
            end
        end
    end

    load_ext u_load_ext (
        .word   (word_q),
        .offset (offset_q),
        .op     (op_q),
        .rdata  (ext_rdata),
        .adel   (ext_adel)
    );

    // Gating on rd_valid makes reset clear the visible outputs immediately.
    assign rd_valid = rd_valid_q;
    assign rdata    = rd_valid_q ? ext_rdata : 32'h0;
    assign adel     = rd_valid_q & ext_adel;
    assign ades     = ades_q;

endmodule

// File: tb/tb_dm_load_unit.sv
// Directed bench for dm_load_unit: a table of one-request-per-cycle vectors
// followed by a hand-written mid-load reset sequence.
module tb_dm_load_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [2:0]  ld_op;
    logic        rd_valid;
    logic [31:0] rdata;
    logic        adel;
    logic        ades;

    int checks = 0;
    int errors = 0;

    dm_load_unit #(.DEPTH_LOG2(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .we        (we),
        .addr      (addr),
        .be        (be),
        .wdata     (wdata),
        .ld_op     (ld_op),
        .rd_valid  (rd_valid),
        .rdata     (rdata),
        .adel      (adel),
        .ades      (ades)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [2:0]  op;
        logic        exp_valid;
        logic [31:0] exp_rdata;
        logic        exp_adel;
        logic        exp_ades;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic vec_t st(input logic [31:0] a, input logic [3:0] b,
                                input logic [31:0] d, input logic bad);
        vec_t v;
        v = '{1'b1, 1'b1, a, b, d, 3'b000, 1'b0, 32'h0, 1'b0, bad};
        return v;
    endfunction

    function automatic vec_t ld(input logic [31:0] a, input logic [2:0] op,
                                input logic [31:0] exp, input logic mis);
        vec_t v;
        v = '{1'b1, 1'b0, a, 4'b0000, 32'h0, op, 1'b1, exp, mis, 1'b0};
        return v;
    endfunction

    function automatic vec_t idle();
        vec_t v;
        v = '{1'b0, 1'b0, 32'h0, 4'b0000, 32'h0, 3'b000, 1'b0, 32'h0, 1'b0, 1'b0};
        return v;
    endfunction

    task automatic drive_idle();
        req_valid = 1'b0;
        we        = 1'b0;
        addr      = '0;
        be        = '0;
        wdata     = '0;
        ld_op     = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive_idle();
        rst_n = 1'b0;

        // Partial store
        vecs.push_back(st(32'h10, 4'b1111, 32'hAABBCCDD, 1'b0));
        vecs.push_back(st(32'h10, 4'b0100, 32'h00EE0000, 1'b0));
        vecs.push_back(ld(32'h10, 3'b000, 32'hAAEECCDD, 1'b0));
        // Extension
        vecs.push_back(st(32'h20, 4'b1111, 32'h80FF7F01, 1'b0));
        vecs.push_back(ld(32'h23, 3'b100, 32'hFFFFFF80, 1'b0));
        vecs.push_back(ld(32'h23, 3'b011, 32'h00000080, 1'b0));
        vecs.push_back(ld(32'h21, 3'b100, 32'h0000007F, 1'b0));
        vecs.push_back(ld(32'h22, 3'b010, 32'hFFFF80FF, 1'b0));
        vecs.push_back(ld(32'h20, 3'b001, 32'h00007F01, 1'b0));
        vecs.push_back(ld(32'h10, 3'b011, 32'h000000DD, 1'b0));
        vecs.push_back(ld(32'h11, 3'b100, 32'hFFFFFFCC, 1'b0));
        vecs.push_back(ld(32'h12, 3'b001, 32'h0000AAEE, 1'b0));
        vecs.push_back(ld(32'h10, 3'b111, 32'hAAEECCDD, 1'b0));
        // Misalignment and illegal enables
        vecs.push_back(ld(32'h21, 3'b000, 32'h00000000, 1'b1));
        vecs.push_back(ld(32'h23, 3'b010, 32'h00000000, 1'b1));
        vecs.push_back(ld(32'h21, 3'b001, 32'h00000000, 1'b1));
        vecs.push_back(st(32'h20, 4'b0110, 32'hFFFFFFFF, 1'b1));
        vecs.push_back(st(32'h20, 4'b0000, 32'hFFFFFFFF, 1'b1));
        vecs.push_back(idle());
        vecs.push_back(ld(32'h20, 3'b000, 32'h80FF7F01, 1'b0));
        vecs.push_back(idle());
        // Back-to-back loads
        vecs.push_back(st(32'h0, 4'b1111, 32'h11111111, 1'b0));
        vecs.push_back(st(32'h4, 4'b1111, 32'h22222222, 1'b0));
        vecs.push_back(st(32'h8, 4'b1111, 32'h33333333, 1'b0));
        vecs.push_back(st(32'hC, 4'b1111, 32'h44444444, 1'b0));
        vecs.push_back(ld(32'h0, 3'b000, 32'h11111111, 1'b0));
        vecs.push_back(ld(32'h4, 3'b000, 32'h22222222, 1'b0));
        vecs.push_back(ld(32'h8, 3'b000, 32'h33333333, 1'b0));
        vecs.push_back(ld(32'hC, 3'b000, 32'h44444444, 1'b0));
        // Store then load, load then store, same word
        vecs.push_back(st(32'h8, 4'b0011, 32'h0000BEEF, 1'b0));
        vecs.push_back(ld(32'h8, 3'b000, 32'h3333BEEF, 1'b0));
        vecs.push_back(st(32'h8, 4'b1111, 32'h5555AAAA, 1'b0));
        vecs.push_back(ld(32'h8, 3'b000, 32'h5555AAAA, 1'b0));
        vecs.push_back(st(32'hA, 4'b1000, 32'h77000000, 1'b0));
        vecs.push_back(ld(32'hB, 3'b011, 32'h00000077, 1'b0));
        // Aliasing
        vecs.push_back(st(32'h1004, 4'b1111, 32'hCAFEF00D, 1'b0));
        vecs.push_back(ld(32'h0004, 3'b000, 32'hCAFEF00D, 1'b0));
        vecs.push_back(idle());

        // Reset state
        #12;
        check("reset_rd_valid", {31'b0, rd_valid}, 32'h0);
        check("reset_rdata", rdata, 32'h0);
        check("reset_adel", {31'b0, adel}, 32'h0);
        check("reset_ades", {31'b0, ades}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            req_valid = vecs[i].req;
            we        = vecs[i].we;
            addr      = vecs[i].addr;
            be        = vecs[i].be;
            wdata     = vecs[i].wdata;
            ld_op     = vecs[i].op;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_rd_valid", i), {31'b0, rd_valid}, {31'b0, vecs[i].exp_valid});
            check($sformatf("v%0d_adel", i), {31'b0, adel}, {31'b0, vecs[i].exp_adel});
            check($sformatf("v%0d_ades", i), {31'b0, ades}, {31'b0, vecs[i].exp_ades});
            if (vecs[i].exp_valid)
                check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
        end

        // Reset in the middle of a load response
        @(negedge clk);
        req_valid = 1'b1; we = 1'b0; addr = 32'h20; ld_op = 3'b000;
        @(posedge clk);
        #1;
        check("midrst_pre_valid", {31'b0, rd_valid}, 32'h1);
        drive_idle();
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_rd_valid", {31'b0, rd_valid}, 32'h0);
        check("midrst_rdata", rdata, 32'h0);
        check("midrst_adel", {31'b0, adel}, 32'h0);
        check("midrst_ades", {31'b0, ades}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("postrst_no_resp", {31'b0, rd_valid}, 32'h0);
        check("postrst_rdata", rdata, 32'h0);

        // Memory survives reset
        @(negedge clk);
        req_valid = 1'b1; we = 1'b0; addr = 32'h10; ld_op = 3'b000;
        @(posedge clk);
        #1;
        check("keep_rd_valid", {31'b0, rd_valid}, 32'h1);
        check("keep_rdata", rdata, 32'hAAEECCDD);
        @(negedge clk);
        drive_idle();
        @(posedge clk);
        #1;
        check("pulse_end", {31'b0, rd_valid}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
